// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the CPU memory
// stage and a debug/loader port; each access ends with a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant_out,
  output logic [1:0]    state_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;          // 1 = debug was served last
  logic [1:0]    grant_q, grant_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          cpu_ready_q, cpu_ready_d;
  logic          dbg_ready_q, dbg_ready_d;
  logic          pick_dbg;

  // On a tie the port that was not served last wins.
  assign pick_dbg = dbg_req && (!cpu_req || !last_q);

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_ready_d = 1'b0;
    dbg_ready_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          mem_en_d    = 1'b1;
          mem_we_d    = pick_dbg ? dbg_we    : cpu_we;
          mem_addr_d  = pick_dbg ? dbg_addr  : cpu_addr;
          mem_wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
          cnt_d       = 4'd0;
          grant_d     = pick_dbg ? 2'b10 : 2'b01;
          last_d      = pick_dbg;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q == WAIT_CNT) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (grant_q[1]) begin
            dbg_rdata_d = mem_rdata;
            dbg_ready_d = 1'b1;
          end else begin
            cpu_rdata_d = mem_rdata;
            cpu_ready_d = 1'b1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      grant_q     <= 2'b00;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      dbg_ready_q <= dbg_ready_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_ready = dbg_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_out = grant_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word-addressed memory model
// answering combinationally from the latched address.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int WAIT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          cpu_ready, dbg_ready, mem_en, mem_we;
  logic [1:0]    grant_out, state_out;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem [0:63];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_out(grant_out), .state_out(state_out)
  );

  // Memory model: preloaded while rst is high, written while enabled for a write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[1] <= 32'hA5A5_A5A5;
      mem[4] <= 32'hDEAD_BEEF;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on the sample right after the grant edge (cnt = 0); walks the rest
  // of ACCESS, the DONE cycle and the return to IDLE.
  task automatic complete(input logic is_dbg, input logic exp_we,
                          input logic [31:0] exp_addr, input logic drop, input string tag);
    for (int i = 0; i < WAIT; i++) begin
      tick();
      check({tag, " access state"}, 32'(state_out), 32'd1);
      check({tag, " mem_en held"}, 32'(mem_en), 32'd1);
      check({tag, " mem_we held"}, 32'(mem_we), 32'(exp_we));
      check({tag, " mem_addr held"}, mem_addr, exp_addr);
      check({tag, " no early ready"}, 32'({dbg_ready, cpu_ready}), 32'd0);
    end
    tick();
    check({tag, " done state"}, 32'(state_out), 32'd2);
    check({tag, " ready pulse"}, 32'({dbg_ready, cpu_ready}), is_dbg ? 32'd2 : 32'd1);
    check({tag, " mem_en cleared"}, 32'(mem_en), 32'd0);
    if (drop) begin
      if (is_dbg) dbg_req = 1'b0;
      else        cpu_req = 1'b0;
    end
    tick();
    check({tag, " idle state"}, 32'(state_out), 32'd0);
    check({tag, " grant cleared"}, 32'(grant_out), 32'd0);
    check({tag, " ready cleared"}, 32'({dbg_ready, cpu_ready}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick();
    tick();

    // Reset values
    check("rst state", 32'(state_out), 32'd0);
    check("rst grant", 32'(grant_out), 32'd0);
    check("rst mem_en/we", 32'({mem_en, mem_we}), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst ready", 32'({dbg_ready, cpu_ready}), 32'd0);
    check("rst cpu_rdata", cpu_rdata, 32'd0);
    check("rst dbg_rdata", dbg_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // CPU read at 0x10
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    check("t1 idle before", 32'(state_out), 32'd0);
    tick();
    check("t1 state", 32'(state_out), 32'd1);
    check("t1 grant", 32'(grant_out), 32'd1);
    check("t1 mem_en", 32'(mem_en), 32'd1);
    check("t1 mem_addr", mem_addr, 32'h10);
    complete(1'b0, 1'b0, 32'h10, 1'b1, "t1");
    check("t1 cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);

    // Address changed while busy stays latched
    cpu_req = 1'b1; cpu_addr = 32'h10;
    tick();
    check("t6 grant", 32'(grant_out), 32'd1);
    cpu_addr = 32'h30;
    complete(1'b0, 1'b0, 32'h10, 1'b1, "t6");
    check("t6 cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);

    // Debug write then debug read-back
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678;
    tick();
    check("t4 grant", 32'(grant_out), 32'd2);
    check("t4 mem_we", 32'(mem_we), 32'd1);
    check("t4 mem_wdata", mem_wdata, 32'h1234_5678);
    complete(1'b1, 1'b1, 32'h20, 1'b1, "t4w");
    dbg_req = 1'b1; dbg_we = 1'b0;
    tick();
    check("t4r grant", 32'(grant_out), 32'd2);
    complete(1'b1, 1'b0, 32'h20, 1'b1, "t4r");
    check("t4r dbg_rdata", dbg_rdata, 32'h1234_5678);

    // Reset at cnt = 1, then the pending CPU request restarts from scratch
    cpu_req = 1'b1; cpu_addr = 32'h10;
    tick();
    tick();
    check("t5 busy before rst", 32'(state_out), 32'd1);
    rst = 1'b1;
    #1;
    check("t5 state", 32'(state_out), 32'd0);
    check("t5 grant", 32'(grant_out), 32'd0);
    check("t5 mem_en/we", 32'({mem_en, mem_we}), 32'd0);
    check("t5 mem_addr", mem_addr, 32'd0);
    check("t5 ready", 32'({dbg_ready, cpu_ready}), 32'd0);
    check("t5 cpu_rdata", cpu_rdata, 32'd0);
    check("t5 dbg_rdata", dbg_rdata, 32'd0);
    tick();
    rst = 1'b0;
    check("t5 no ready in rst", 32'(cpu_ready), 32'd0);
    tick();
    check("t5 regrant", 32'(grant_out), 32'd1);
    complete(1'b0, 1'b0, 32'h10, 1'b1, "t5");
    check("t5 cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);

    // Fresh reset, both ports request continuously: 01,10,01,10
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h8; dbg_wdata = 32'h55;
    tick();
    check("t2 grant 1", 32'(grant_out), 32'd1);
    check("t2 mem_addr 1", mem_addr, 32'h4);
    complete(1'b0, 1'b0, 32'h4, 1'b0, "t2a");
    check("t2 cpu_rdata", cpu_rdata, 32'hA5A5_A5A5);
    tick();
    check("t2 grant 2", 32'(grant_out), 32'd2);
    check("t2 mem_wdata", mem_wdata, 32'h55);
    complete(1'b1, 1'b1, 32'h8, 1'b0, "t2b");
    tick();
    check("t3 grant 3", 32'(grant_out), 32'd1);
    complete(1'b0, 1'b0, 32'h4, 1'b0, "t3c");
    tick();
    check("t3 grant 4", 32'(grant_out), 32'd2);
    complete(1'b1, 1'b1, 32'h8, 1'b1, "t3d");
    cpu_req = 1'b0;
    check("t3 mem written", mem[2], 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
